// File: rtl/slow_edge_bcd_timer.sv
`default_nettype none
// ============================================================================
// Module      : slow_edge_bcd_timer
// Description : Detects rising edges of the divided SLOW square wave and
//               counts them into a multi-digit BCD up/down counter. A
//               run/pause/idle state machine decides when edges are counted.
// Ports       : CLOCK   - fast system clock, rising-edge active
//               RESET   - synchronous, active-high reset
//               SLOW    - divided square wave, same clock domain
//               START   - request RUN (from IDLE or PAUSE)
//               STOP    - request PAUSE (from RUN)
//               CLEAR   - zero the count and return to IDLE
//               UP      - count direction, 1 = increment, 0 = decrement
//               DIGITS  - BCD count, digit 0 in [3:0]
//               RUNNING - high while in RUN
//               TICK    - one-cycle pulse per counted edge
//               WRAP    - one-cycle pulse when the count wraps
// Revision    : 1.0 - initial release
// ============================================================================
module slow_edge_bcd_timer #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    SLOW,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    CLEAR,
  input  logic                    UP,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic                    RUNNING,
  output logic                    TICK,
  output logic                    WRAP
);

  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic              slow_q;
  logic              running_q, running_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;

  logic              slow_rise;
  logic              count_en;
  logic [DW-1:0]     digits_step;
  logic [NUM_DIGITS:0] carry;

  assign slow_rise = SLOW & ~slow_q;

  // Ripple chain shared by increment and decrement: carry[i] means digit i
  // must move. A digit at its limit (9 going up, 0 going down) rolls over
  // and passes the carry/borrow on; carry out of the top digit is a wrap.
  assign carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [3:0] cur;
      logic       at_limit;
      logic [3:0] nxt;

      assign cur      = digits_q[4*i +: 4];
      assign at_limit = UP ? (cur == 4'd9) : (cur == 4'd0);
      assign carry[i+1] = carry[i] & at_limit;
      assign nxt = !carry[i] ? cur :
                   at_limit  ? (UP ? 4'd0 : 4'd9) :
                               (UP ? cur + 4'd1 : cur - 4'd1);
      assign digits_step[4*i +: 4] = nxt;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;

    // Any STOP or CLEAR in the same cycle drops the edge; an edge arriving
    // together with START outside RUN is also dropped because state_q is
    // not yet RUN.
    count_en = (state_q == ST_RUN) & slow_rise & ~CLEAR & ~STOP;

    if (count_en) begin
      digits_d = digits_step;
    end
    tick_d = count_en;
    wrap_d = count_en & carry[NUM_DIGITS];

    if (CLEAR) begin
      state_d  = ST_IDLE;
      digits_d = '0;
    end else if (STOP) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (START) begin
      if ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) begin
        state_d = ST_RUN;
      end
    end

    // Encoding 3 is unreachable in normal operation; recover to a clean IDLE.
    if ((state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_PAUSE)) begin
      state_d  = ST_IDLE;
      digits_d = '0;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLOCK) begin
    // SLOW is tracked during reset too, so a level already high at release
    // is not mistaken for a rising edge.
    slow_q <= SLOW;
    if (RESET) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign DIGITS  = digits_q;
  assign RUNNING = running_q;
  assign TICK    = tick_q;
  assign WRAP    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_edge_bcd_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_edge_bcd_timer
// Description : Self-checking bench for slow_edge_bcd_timer. A reference
//               model keeps the count as a plain integer and the mode as a
//               small integer, and converts to BCD only for comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_edge_bcd_timer;

  localparam int ND   = 4;
  localparam int MAXV = 10000;

  logic          CLOCK = 1'b0;
  logic          RESET, SLOW, START, STOP, CLEAR, UP;
  logic [4*ND-1:0] DIGITS;
  logic          RUNNING, TICK, WRAP;

  always #5 CLOCK = ~CLOCK;

  slow_edge_bcd_timer #(.NUM_DIGITS(ND)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .SLOW   (SLOW),
    .START  (START),
    .STOP   (STOP),
    .CLEAR  (CLEAR),
    .UP     (UP),
    .DIGITS (DIGITS),
    .RUNNING(RUNNING),
    .TICK   (TICK),
    .WRAP   (WRAP)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: 0 = idle, 1 = run, 2 = pause; count as an integer.
  int m_val   = 0;
  int m_state = 0;
  bit m_prev  = 1'b0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4*ND+2:0] exp_vec();
    return {to_bcd(m_val), (m_state == 1), m_tick, m_wrap};
  endfunction

  // Drive one cycle of inputs, let the DUT and the model take the same edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic step(input logic r, input logic s, input logic st,
                      input logic sp, input logic cl, input logic u);
    bit rise, cnt;
    RESET = r; SLOW = s; START = st; STOP = sp; CLEAR = cl; UP = u;
    @(posedge CLOCK);
    if (r) begin
      m_state = 0; m_val = 0; m_tick = 0; m_wrap = 0; m_prev = s;
    end else begin
      rise   = s && !m_prev;
      m_prev = s;
      cnt    = (m_state == 1) && rise && !cl && !sp;
      m_tick = cnt;
      m_wrap = 0;
      if (cnt) begin
        if (u) begin
          m_val  = (m_val + 1) % MAXV;
          m_wrap = (m_val == 0);
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MAXV - 1) % MAXV;
        end
      end
      if (cl) begin
        m_state = 0; m_val = 0;
      end else if (sp) begin
        if (m_state == 1) m_state = 2;
      end else if (st) begin
        m_state = 1;
      end
    end
    #1;
  endtask

  task automatic pulse_edge(input logic u);
    step(0, 0, 0, 0, 0, u);
    step(0, 1, 0, 0, 0, u);
  endtask

  task automatic restart_from_zero();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 1);
      n_cmp++;
      if ({DIGITS, RUNNING, TICK, WRAP} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h required %h", {DIGITS, RUNNING, TICK, WRAP}, 19'h0);
      end
    end
    step(0, 1, 1, 0, 0, 1);
    n_cmp++;
    if (DIGITS !== 16'h0000 || RUNNING !== 1'b1 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL start_after_reset: got d=%h run=%b tick=%b required d=0000 run=1 tick=0",
               DIGITS, RUNNING, TICK);
    end
    pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0001 || TICK !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge: got d=%h tick=%b required d=0001 tick=1", DIGITS, TICK);
    end
    step(0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (TICK !== 1'b0 || DIGITS !== 16'h0001) begin
      n_fail++;
      $display("FAIL tick_one_cycle: got d=%h tick=%b required d=0001 tick=0", DIGITS, TICK);
    end
  endtask

  task automatic test_carry();
    int ticks;
    restart_from_zero();
    for (int i = 0; i < 98; i++) pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0098) begin
      n_fail++;
      $display("FAIL carry_start: got %h required 0098", DIGITS);
    end
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      pulse_edge(1);
      ticks += int'(TICK);
      n_cmp++;
      if ({DIGITS, RUNNING, TICK, WRAP} !== exp_vec()) begin
        n_fail++;
        $display("FAIL carry_step%0d: got %h required %h", i, {DIGITS, RUNNING, TICK, WRAP}, exp_vec());
      end
      if (i == 1) begin
        n_cmp++;
        if (DIGITS !== 16'h0100) begin
          n_fail++;
          $display("FAIL carry_ripple: got %h required 0100", DIGITS);
        end
      end
    end
    n_cmp++;
    if (DIGITS !== 16'h0198 || ticks != 100) begin
      n_fail++;
      $display("FAIL carry_final: got d=%h ticks=%0d required d=0198 ticks=100", DIGITS, ticks);
    end
  endtask

  task automatic test_wrap();
    restart_from_zero();
    pulse_edge(0);
    n_cmp++;
    if (DIGITS !== 16'h9999 || WRAP !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down_from_zero: got d=%h wrap=%b required d=9999 wrap=1", DIGITS, WRAP);
    end
    step(0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (WRAP !== 1'b0 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: got wrap=%b tick=%b required wrap=0 tick=0", WRAP, TICK);
    end
    pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0000 || WRAP !== 1'b1 || TICK !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up: got d=%h wrap=%b tick=%b required d=0000 wrap=1 tick=1", DIGITS, WRAP, TICK);
    end
    pulse_edge(0);
    n_cmp++;
    if (DIGITS !== 16'h9999 || WRAP !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: got d=%h wrap=%b required d=9999 wrap=1", DIGITS, WRAP);
    end
    pulse_edge(0);
    n_cmp++;
    if (DIGITS !== 16'h9998 || WRAP !== 1'b0) begin
      n_fail++;
      $display("FAIL no_wrap_down: got d=%h wrap=%b required d=9998 wrap=0", DIGITS, WRAP);
    end
  endtask

  task automatic test_stop_edge();
    restart_from_zero();
    for (int i = 0; i < 5; i++) pulse_edge(1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    n_cmp++;
    if (DIGITS !== 16'h0005 || TICK !== 1'b0 || RUNNING !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_with_edge: got d=%h tick=%b run=%b required d=0005 tick=0 run=0",
               DIGITS, TICK, RUNNING);
    end
    pulse_edge(1);
    pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0005 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_holds: got d=%h tick=%b required d=0005 tick=0", DIGITS, TICK);
    end
    step(0, 0, 1, 0, 0, 1);
    pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0006 || RUNNING !== 1'b1 || TICK !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got d=%h run=%b tick=%b required d=0006 run=1 tick=1", DIGITS, RUNNING, TICK);
    end
  endtask

  task automatic test_start_edge();
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 1);
    n_cmp++;
    if (DIGITS !== 16'h0000 || RUNNING !== 1'b1 || TICK !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_edge: got d=%h run=%b tick=%b required d=0000 run=1 tick=0",
               DIGITS, RUNNING, TICK);
    end
    pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0001 || TICK !== 1'b1) begin
      n_fail++;
      $display("FAIL start_next_edge: got d=%h tick=%b required d=0001 tick=1", DIGITS, TICK);
    end
  endtask

  task automatic test_clear_and_reset();
    restart_from_zero();
    for (int i = 0; i < 42; i++) pulse_edge(1);
    n_cmp++;
    if (DIGITS !== 16'h0042) begin
      n_fail++;
      $display("FAIL reach_42: got %h required 0042", DIGITS);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    n_cmp++;
    if ({DIGITS, RUNNING, TICK, WRAP} !== 19'h0) begin
      n_fail++;
      $display("FAIL clear_all: got %h required %h", {DIGITS, RUNNING, TICK, WRAP}, 19'h0);
    end
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) pulse_edge(1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    n_cmp++;
    if ({DIGITS, RUNNING, TICK, WRAP} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h required %h", {DIGITS, RUNNING, TICK, WRAP}, 19'h0);
    end
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (DIGITS !== 16'h0000 || TICK !== 1'b0 || RUNNING !== 1'b1) begin
      n_fail++;
      $display("FAIL no_spurious_edge: got d=%h tick=%b run=%b required d=0000 tick=0 run=1",
               DIGITS, TICK, RUNNING);
    end
  endtask

  task automatic test_random();
    logic r, s, st, sp, cl, u;
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0) s = ~s;
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 23) == 0);
      cl = ($urandom_range(0, 199) == 0);
      u  = ($urandom_range(0, 4) != 0);
      step(r, s, st, sp, cl, u);
      n_cmp++;
      if ({DIGITS, RUNNING, TICK, WRAP} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h required %h", i, {DIGITS, RUNNING, TICK, WRAP}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_wrap();
    test_stop_edge();
    test_start_edge();
    test_clear_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slow_edge_bcd_timer.md
Name: slow_edge_bcd_timer

Overview:
- Downstream consumer of the divided slow square wave produced by the clock-divider stage.
- Runs in the same fast CLOCK domain and detects each rising edge of SLOW.
- Counts those edges as seconds-style ticks into a multi-digit BCD up/down counter.
- Controlled by a run/pause/idle state machine. DIGITS feeds the display stage.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; DIGITS width is 4*NUM_DIGITS.

Ports:
- CLOCK  input  1  fast system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- SLOW  input  1  divided square wave from the clock-divider stage; same clock domain, no synchroniser.
- START  input  1  level-sampled each cycle; requests run.
- STOP  input  1  level-sampled each cycle; requests pause.
- CLEAR  input  1  level-sampled each cycle; zeroes count and returns to IDLE.
- UP  input  1  count direction: 1 = increment, 0 = decrement. Sampled on the counting cycle.
- DIGITS  output  4*NUM_DIGITS  BCD count; digit 0 in [3:0] is least significant.
- RUNNING  output  1  high while in state RUN.
- TICK  output  1  one-cycle pulse, registered, on each counted edge.
- WRAP  output  1  one-cycle pulse, registered, when the count wraps.

Behaviour:
- Reset: clock is CLOCK; reset is RESET, synchronous and active-high. While RESET is high at a clock edge:
  - state <= IDLE; DIGITS <= 0; RUNNING, TICK and WRAP <= 0.
  - SLOW_d <= SLOW, so a SLOW already high at reset release never produces a spurious edge.
  - RESET overrides all other inputs.
- Edge detect: edge = SLOW & ~SLOW_d, evaluated combinationally before each clock edge. SLOW_d <= SLOW every non-reset cycle.
- States:
  - IDLE (enc 0), RUN (enc 1), PAUSE (enc 2).
  - Encoding 3 is illegal and returns to IDLE with DIGITS cleared.
- Transitions per cycle, priority CLEAR > STOP > START:
  - CLEAR: any state -> IDLE, DIGITS <= 0.
  - STOP: RUN -> PAUSE. In IDLE or PAUSE, STOP is a no-op.
  - START: IDLE -> RUN and PAUSE -> RUN. In RUN, START is a no-op.
- Counting:
  - A count happens at a clock edge only if all hold: current state == RUN, edge == 1, CLEAR == 0, STOP == 0.
  - DIGITS updates at that same clock edge. Latency is 0 cycles from the first clock edge that samples SLOW high.
  - TICK is high for exactly the following cycle.
- Simultaneous events:
  - START together with an edge while in IDLE or PAUSE: state goes to RUN, but that edge is not counted.
  - STOP or CLEAR together with an edge in RUN: the edge is dropped.
- Increment arithmetic:
  - Digit 0 += 1; a digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 -> all 0 with WRAP = 1 for one cycle.
- Decrement arithmetic:
  - Digit 0 -= 1; a digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 -> all 9 with WRAP = 1 for one cycle.
- Value range: digit values 10-15 are never produced.
- Direction change: UP may change at any time; it only affects the counting cycle in which it is sampled.
- Outputs:
  - RUNNING is registered and equals (state == RUN). It reflects a transition one cycle after the controlling input is sampled.
  - TICK and WRAP are low at all other times.
- Pause and idle behaviour:
  - PAUSE holds DIGITS unchanged indefinitely.
  - IDLE holds DIGITS at 0 only after CLEAR or reset. Returning to IDLE is only possible via CLEAR, so IDLE always has a zero count.
- Reset mid-run: reset takes effect at the next clock edge, regardless of edge, START, STOP or CLEAR.

Test Plan:
- RESET held 3 cycles with SLOW=1, then released with SLOW staying 1; pulse START -> RUNNING=1 next cycle, no TICK, DIGITS=0x0000. Then SLOW 0->1 -> DIGITS=0x0001 and TICK pulses once.
- UP=1 in RUN, 100 SLOW rising edges starting from 0x0098 -> passes 0x0099 -> 0x0100 (carry ripple); final DIGITS=0x0198; exactly 100 TICK pulses.
- Counter at 0x9999 in RUN with UP=1, one edge -> DIGITS=0x0000 and WRAP=1 for one cycle. Then UP=0, one edge -> DIGITS=0x9999 with WRAP pulse.
- In RUN at 0x0005, assert STOP in the same cycle as a rising edge -> DIGITS stays 0x0005, no TICK, RUNNING=0. Further edges are ignored. START then one edge -> 0x0006.
- START asserted in IDLE together with a rising edge -> RUNNING=1, DIGITS=0x0000, no TICK. Next edge -> 0x0001.
- In RUN at 0x0042, assert CLEAR, STOP and START together with an edge -> state IDLE, DIGITS=0x0000, RUNNING=0, no TICK/WRAP. Separately, RESET asserted mid-RUN -> all outputs zero after one clock.
